// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register with valid/ready handshake.
// Entries carry the ALU result, store data, destination register and
// control bits. A misaligned-access flag is computed as each entry is taken.
// Optional feature macro: EX_MEM_SKID_EN
//   defined   -> 2-entry skid buffer, in_ready fully registered
//   undefined -> single register, in_ready = !out_valid || out_ready
// Reset is synchronous and active-low.

module ex_mem_stage #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] ALUResult,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd,
    input  logic            RegWrite,
    input  logic            MemRead,
    input  logic            MemWrite,
    input  logic            MemToReg,
    input  logic [2:0]      funct3,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_ALUResult,
    output logic [XLEN-1:0] out_store_data,
    output logic [4:0]      out_rd,
    output logic            out_RegWrite,
    output logic            out_MemRead,
    output logic            out_MemWrite,
    output logic            out_MemToReg,
    output logic [2:0]      out_funct3,
    output logic            out_misaligned
);

    typedef struct packed {
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] sdata;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic [2:0]      funct3;
        logic            misaligned;
    } entry_t;

    logic [1:0] r_count;      // entries held: 0..2 (skid) or 0..1
    entry_t     r_head;       // entry presented on the out_* ports
    logic       r_rdy;        // low during reset, and when full in skid mode
    logic [1:0] w_count_nxt;
    entry_t     w_head_nxt;
    entry_t     w_in;
    logic       w_misaligned;
    logic       w_valid;
    logic       w_push;
    logic       w_pop;

`ifdef EX_MEM_SKID_EN
    entry_t     r_skid;       // second entry, only meaningful when r_count == 2
    entry_t     w_skid_nxt;
`endif

    // Alignment check on the incoming access; byte accesses never misalign.
    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_misaligned = 1'b0;
        if (MemRead || MemWrite) begin
            case (funct3[1:0])
                2'b01:   w_misaligned = ALUResult[0];
                2'b10:   w_misaligned = |ALUResult[1:0];
                2'b11:   w_misaligned = |ALUResult[2:0];
                default: w_misaligned = 1'b0;
            endcase
        end
    end

    // Incoming entry as it will be stored; writes to x0 are suppressed here.
    always_comb begin
        w_in            = '0;
        w_in.alu        = ALUResult;
        w_in.sdata      = store_data;
        w_in.rd         = rd;
        w_in.reg_write  = RegWrite && (rd != 5'd0);
        w_in.mem_read   = MemRead;
        w_in.mem_write  = MemWrite;
        w_in.mem_to_reg = MemToReg;
        w_in.funct3     = funct3;
        w_in.misaligned = w_misaligned;
    end

    assign w_valid = (r_count != 2'd0);
    assign w_push  = in_valid && in_ready;
    assign w_pop   = w_valid && out_ready;

`ifdef EX_MEM_SKID_EN
    assign in_ready = r_rdy;
`else
    assign in_ready = r_rdy && (!w_valid || out_ready);
`endif

    // Next occupancy and entry contents; flush wins over accept and deliver.
    always_comb begin
        w_count_nxt = r_count;
        w_head_nxt  = r_head;
`ifdef EX_MEM_SKID_EN
        w_skid_nxt  = r_skid;
`endif
        if (flush) begin
            w_count_nxt = 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
`ifdef EX_MEM_SKID_EN
                    if (r_count == 2'd0) begin
                        w_head_nxt  = w_in;
                        w_count_nxt = 2'd1;
                    end else begin
                        w_skid_nxt  = w_in;
                        w_count_nxt = 2'd2;
                    end
`else
                    w_head_nxt  = w_in;
                    w_count_nxt = 2'd1;
`endif
                end
                2'b01: begin
`ifdef EX_MEM_SKID_EN
                    if (r_count == 2'd2) begin
                        w_head_nxt  = r_skid;
                        w_count_nxt = 2'd1;
                    end else begin
                        w_count_nxt = 2'd0;
                    end
`else
                    w_count_nxt = 2'd0;
`endif
                end
                // Simultaneous accept and deliver only happens with one entry
                // held, so the new entry replaces the head and occupancy stays.
                2'b11: w_head_nxt = w_in;
                default: ;
            endcase
        end
    end

    // Occupancy, head entry and ready flag registers with synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_head  <= '0;
            r_rdy   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_head  <= w_head_nxt;
`ifdef EX_MEM_SKID_EN
            r_rdy   <= (w_count_nxt != 2'd2);
`else
            r_rdy   <= 1'b1;
`endif
        end
    end

`ifdef EX_MEM_SKID_EN
    // Skid entry storage.
    // NOTE: this data register is deliberately not reset; it is only read
    // when r_count == 2, and r_count itself is reset.
    always_ff @(posedge clk) begin
        r_skid <= w_skid_nxt;
    end
`endif

    assign out_valid      = w_valid;
    assign out_ALUResult  = r_head.alu;
    assign out_store_data = r_head.sdata;
    assign out_rd         = r_head.rd;
    assign out_RegWrite   = r_head.reg_write;
    assign out_MemRead    = r_head.mem_read;
    assign out_MemWrite   = r_head.mem_write;
    assign out_MemToReg   = r_head.mem_to_reg;
    assign out_funct3     = r_head.funct3;
    assign out_misaligned = r_head.misaligned;

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed and randomized checks of ex_mem_stage against a
// queue-based reference model. Works with or without EX_MEM_SKID_EN.

module tb_ex_mem_stage;

    typedef struct packed {
        logic [63:0] alu;
        logic [63:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic [2:0]  f3;
        logic        mis;
    } ent_t;

    typedef struct packed {
        logic        rst_n;
        logic        flush;
        logic        in_valid;
        logic        out_ready;
        logic [63:0] alu;
        logic [63:0] sd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
        logic [2:0]  f3;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] ALUResult = '0;
    logic [63:0] store_data = '0;
    logic [4:0]  rd = '0;
    logic        RegWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic        MemToReg = 1'b0;
    logic [2:0]  funct3 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_ALUResult;
    logic [63:0] out_store_data;
    logic [4:0]  out_rd;
    logic        out_RegWrite;
    logic        out_MemRead;
    logic        out_MemWrite;
    logic        out_MemToReg;
    logic [2:0]  out_funct3;
    logic        out_misaligned;

    ex_mem_stage #(.XLEN(64)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .ALUResult      (ALUResult),
        .store_data     (store_data),
        .rd             (rd),
        .RegWrite       (RegWrite),
        .MemRead        (MemRead),
        .MemWrite       (MemWrite),
        .MemToReg       (MemToReg),
        .funct3         (funct3),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ALUResult  (out_ALUResult),
        .out_store_data (out_store_data),
        .out_rd         (out_rd),
        .out_RegWrite   (out_RegWrite),
        .out_MemRead    (out_MemRead),
        .out_MemWrite   (out_MemWrite),
        .out_MemToReg   (out_MemToReg),
        .out_funct3     (out_funct3),
        .out_misaligned (out_misaligned)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    ent_t q[$];            // entries in flight, oldest first
    logic m_rdy   = 1'b0;  // model: stage out of reset
    logic m_known = 1'b0;  // model: at least one reset edge seen

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected stored entry, from the architectural rules.
    function automatic ent_t mk(input stim_t s);
        ent_t        e;
        logic [63:0] size;
        size  = 64'd1 << s.f3[1:0];
        e.alu = s.alu;
        e.sd  = s.sd;
        e.rd  = s.rd;
        e.rw  = s.rw && (s.rd != 5'd0);
        e.mr  = s.mr;
        e.mw  = s.mw;
        e.m2r = s.m2r;
        e.f3  = s.f3;
        e.mis = (s.mr || s.mw) && ((s.alu % size) != 64'd0);
        return e;
    endfunction

    function automatic ent_t obs();
        return {out_ALUResult, out_store_data, out_rd, out_RegWrite, out_MemRead,
                out_MemWrite, out_MemToReg, out_funct3, out_misaligned};
    endfunction

    function automatic stim_t idle(input logic ordy);
        stim_t s;
        s           = '0;
        s.rst_n     = 1'b1;
        s.out_ready = ordy;
        return s;
    endfunction

    function automatic stim_t push(input logic [63:0] alu, input logic [4:0] r, input logic ordy);
        stim_t s;
        s          = idle(ordy);
        s.in_valid = 1'b1;
        s.alu      = alu;
        s.sd       = ~alu;
        s.rd       = r;
        s.rw       = 1'b1;
        return s;
    endfunction

    // One clock: drive at negedge, compare against the model, then advance it.
    task automatic step(input stim_t s);
        logic exp_rdy;
        logic pop;
        @(negedge clk);
        rst_n      = s.rst_n;
        flush      = s.flush;
        in_valid   = s.in_valid;
        out_ready  = s.out_ready;
        ALUResult  = s.alu;
        store_data = s.sd;
        rd         = s.rd;
        RegWrite   = s.rw;
        MemRead    = s.mr;
        MemWrite   = s.mw;
        MemToReg   = s.m2r;
        funct3     = s.f3;
        #1;
        exp_rdy = 1'b0;
        if (m_known) begin
`ifdef EX_MEM_SKID_EN
            exp_rdy = m_rdy && (q.size() < 2);
`else
            exp_rdy = m_rdy && (q.size() == 0 || s.out_ready);
`endif
            check("in_ready", in_ready, exp_rdy);
            check("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) check("entry", obs(), q[0]);
        end
        @(posedge clk);
        if (!s.rst_n) begin
            q.delete();
            m_rdy   = 1'b0;
            m_known = 1'b1;
        end else begin
            m_rdy = 1'b1;
            if (s.flush) begin
                q.delete();
            end else begin
                pop = (q.size() != 0) && s.out_ready;
                if (pop) void'(q.pop_front());
                if (s.in_valid && exp_rdy) q.push_back(mk(s));
            end
        end
    endtask

    initial begin
        stim_t s;

        // Reset: everything cleared, in_ready low, then high one cycle after release.
        s = idle(1'b0);
        s.rst_n = 1'b0;
        step(s);
        step(s);
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_alu", out_ALUResult, 64'd0);
        step(idle(1'b1));
        #2;
        check("rel_in_ready", in_ready, 1'b1);

        // Basic pass-through with one cycle latency.
        step(push(64'd15, 5'd5, 1'b1));
        #2;
        check("b_valid", out_valid, 1'b1);
        check("b_alu", out_ALUResult, 64'd15);
        check("b_rd", out_rd, 5'd5);
        check("b_rw", out_RegWrite, 1'b1);
        step(idle(1'b1));
        #2;
        check("b_drain", out_valid, 1'b0);

        // Write to x0 suppressed.
        step(push(64'd3, 5'd0, 1'b1));
        #2;
        check("x0_rw", out_RegWrite, 1'b0);

        // Misaligned flag cases.
        s = push(64'h1002, 5'd1, 1'b1);
        s.mr = 1'b1;
        s.f3 = 3'b010;
        step(s);
        #2;
        check("mis_word", out_misaligned, 1'b1);
        s.f3  = 3'b000;
        s.alu = 64'h1003;
        step(s);
        #2;
        check("mis_byte", out_misaligned, 1'b0);
        s.mr  = 1'b0;
        s.f3  = 3'b011;
        s.alu = 64'h7;
        step(s);
        #2;
        check("mis_nomem", out_misaligned, 1'b0);
        step(idle(1'b1));

        // Back-pressure: push A and B while the consumer stalls.
        step(push(64'd1, 5'd2, 1'b0));
        step(push(64'd2, 5'd3, 1'b0));
        #2;
        check("bp_in_ready", in_ready, 1'b0);
        check("bp_alu_a", out_ALUResult, 64'd1);
        step(idle(1'b0));
        #2;
        check("bp_stable", out_ALUResult, 64'd1);
        step(idle(1'b1));
`ifdef EX_MEM_SKID_EN
        #2;
        check("bp_alu_b", out_ALUResult, 64'd2);
        check("bp_valid_b", out_valid, 1'b1);
        step(idle(1'b1));
`endif
        #2;
        check("bp_empty", out_valid, 1'b0);

        // Flush with entries held and a simultaneous presented entry.
        step(push(64'd10, 5'd4, 1'b0));
        step(push(64'd11, 5'd4, 1'b0));
        s = push(64'd99, 5'd6, 1'b0);
        s.flush = 1'b1;
        step(s);
        #2;
        check("fl_valid", out_valid, 1'b0);
        step(idle(1'b1));
        #2;
        check("fl_not_acc", out_valid, 1'b0);

        // Reset mid-operation with an entry held.
        s = push(64'h1002, 5'd7, 1'b0);
        s.mr = 1'b1;
        s.f3 = 3'b010;
        step(s);
        s = idle(1'b0);
        s.rst_n = 1'b0;
        step(s);
        #2;
        check("mr_valid", out_valid, 1'b0);
        check("mr_fields", obs(), 141'd0);
        check("mr_in_ready", in_ready, 1'b0);
        step(idle(1'b0));
        #2;
        check("mr_rel_ready", in_ready, 1'b1);
        check("mr_no_ghost", out_valid, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            s           = '0;
            s.rst_n     = ($urandom_range(0, 199) != 0);
            s.flush     = ($urandom_range(0, 39) == 0);
            s.in_valid  = ($urandom_range(0, 9) < 7);
            s.out_ready = ($urandom_range(0, 9) < 6);
            s.alu       = {$urandom, $urandom};
            s.sd        = {$urandom, $urandom};
            s.rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            s.rw        = 1'($urandom);
            s.mr        = 1'($urandom);
            s.mw        = 1'($urandom);
            s.m2r       = 1'($urandom);
            s.f3        = 3'($urandom);
            step(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, datapath width of the ALU result and store data.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port flush  input  1  discard all held entries (branch/exception redirect).
REQ-005 SHALL have port in_valid  input  1  execute stage presents a result.
REQ-006 SHALL have port in_ready  output  1  stage accepts the presented result this cycle.
REQ-007 SHALL have port ALUResult  input  XLEN  ALU output (address or arithmetic result).
REQ-008 SHALL have port store_data  input  XLEN  rs2 value for stores.
REQ-009 SHALL have port rd  input  5  destination register index.
REQ-010 SHALL have ports RegWrite, MemRead, MemWrite, MemToReg  input  1 each  control bits.
REQ-011 SHALL have port funct3  input  3  memory access size/sign code.
REQ-012 SHALL have port out_valid  output  1  memory stage entry valid.
REQ-013 SHALL have port out_ready  input  1  memory stage consumes the entry this cycle.
REQ-014 SHALL have ports out_ALUResult, out_store_data (XLEN), out_rd (5), out_RegWrite, out_MemRead, out_MemWrite, out_MemToReg (1), out_funct3 (3)  output  registered copies.
REQ-015 SHALL have port out_misaligned  output  1  registered misaligned-access flag.

Function
REQ-016 SHALL accept an entry when in_valid && in_ready, and deliver it when out_valid && out_ready.
REQ-017 SHALL present an accepted entry on the out_* ports exactly 1 cycle after acceptance when the stage was empty.
REQ-018 SHALL deliver entries in strict acceptance order; no entry is dropped or duplicated except by flush.
REQ-019 SHALL hold all out_* ports stable while out_valid && !out_ready.
REQ-020 SHALL force the stored RegWrite to 0 when rd == 0.
REQ-021 SHALL compute misaligned at acceptance: asserted only if MemRead||MemWrite and (funct3[1:0]==01 && ALUResult[0]) or (==10 && ALUResult[1:0]!=0) or (==11 && ALUResult[2:0]!=0); byte accesses are never misaligned.
REQ-022 SHALL, on flush, empty all entries so out_valid=0 the next cycle; flush overrides a simultaneous accept and a simultaneous deliver.
REQ-023 SHALL treat a simultaneous accept and deliver as occupancy-neutral.

Reset
REQ-024 SHALL, while rst_n=0 at a clock edge, clear occupancy, drive out_valid=0 and all out_* data/control ports to 0.
REQ-025 SHALL drive in_ready=0 during the reset cycle and in_ready=1 on the first cycle after rst_n returns high.
REQ-026 SHALL abandon any held entries when reset is asserted mid-operation; none reappear after reset.

Configuration
REQ-027 SHALL, with EX_MEM_SKID_EN defined, implement a 2-entry skid buffer: in_ready is registered, equal to (occupancy < 2), with no combinational path from out_ready.
REQ-028 SHALL, with EX_MEM_SKID_EN undefined, implement a single register: in_ready = !out_valid || out_ready (combinational), enabling accept on the same cycle the held entry is delivered.
REQ-029 SHALL provide identical ordering, latency (REQ-017), flush and reset behaviour in both configurations.

Verification
REQ-030 SHALL cover: ALUResult=15, rd=5, RegWrite=1, in_valid 1 cycle, out_ready=1 -> out_valid=1 next cycle with out_ALUResult=15, out_rd=5, then out_valid=0.
REQ-031 SHALL cover: rd=0, RegWrite=1 -> out_RegWrite=0.
REQ-032 SHALL cover: MemRead=1, funct3=010, ALUResult=0x1002 -> out_misaligned=1; funct3=000, ALUResult=0x1003 -> out_misaligned=0; MemRead=MemWrite=0, funct3=011, ALUResult=0x7 -> out_misaligned=0.
REQ-033 SHALL cover (skid): out_ready=0, push A=1, B=2 -> in_ready=0 after 2 accepts, out_ALUResult=1 stable; raise out_ready -> 1 then 2 delivered in order.
REQ-034 SHALL cover: two entries held, flush=1 with in_valid=1 -> out_valid=0 next cycle and the presented entry is not accepted.
REQ-035 SHALL cover: rst_n=0 with an entry held -> all out_* = 0 and out_valid=0; in_ready=1 one cycle after rst_n=1.
